// File: rtl/cdc_multi_ch_sync_filter.sv
// cdc_multi_ch_sync_filter
//
// Brings NUM_CH asynchronous single-bit inputs into the clk_b domain. Each
// channel has three parts:
//   - a STAGES-deep flop chain;
//   - a stability filter that only accepts a new level once the synchronized
//     value has differed from the current level for FILTER_CYCLES consecutive
//     cycles;
//   - registered one-cycle rise/fall event pulses derived from that level.
//
// Ports:
//   clk_b       in   1       destination-domain clock, all flops on posedge
//   sync_rst_n  in   1       synchronous active-low reset
//   async_in    in   NUM_CH  asynchronous inputs, one bit per channel
//   level_out   out  NUM_CH  filtered synchronized level
//   rise_pulse  out  NUM_CH  one cycle high on the first cycle of level 1
//   fall_pulse  out  NUM_CH  one cycle high on the first cycle of level 0
//   pending     out  NUM_CH  high while a level change is qualifying
module cdc_multi_ch_sync_filter #(
  parameter int                NUM_CH        = 4,
  parameter int                STAGES        = 2,
  parameter int                FILTER_CYCLES = 3,
  parameter logic [NUM_CH-1:0] RESET_VAL     = {NUM_CH{1'b0}}
) (
  input  logic              clk_b,
  input  logic              sync_rst_n,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] pending
);

  localparam int              CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  if (STAGES < 2) begin : g_bad_stages
    $error("cdc_multi_ch_sync_filter: STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("cdc_multi_ch_sync_filter: FILTER_CYCLES must be >= 1");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("cdc_multi_ch_sync_filter: NUM_CH must be >= 1");
  end

  // The counter never passes CNT_LAST: reaching it commits the new level and
  // clears the count instead, so a plain increment cannot wrap.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    return cnt + CNT_W'(1);
  endfunction

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [STAGES-1:0] sync_p0;
    logic              sync_raw;
    logic              filt_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic              filt_d_p2;

    // Stage 0: synchronizer chain; async_in only ever reaches sync_p0[0],
    // with nothing but flops between the chain stages.
    always_ff @(posedge clk_b) begin
      if (!sync_rst_n) begin
        sync_p0 <= {STAGES{RESET_VAL[ch]}};
      end else begin
        sync_p0 <= {sync_p0[STAGES-2:0], async_in[ch]};
      end
    end

    assign sync_raw = sync_p0[STAGES-1];

    // Stage 1: stability filter. Any cycle where the synchronized value
    // agrees with the current level discards the partial qualification.
    always_ff @(posedge clk_b) begin
      if (!sync_rst_n) begin
        filt_p1 <= RESET_VAL[ch];
        cnt_p1  <= '0;
      end else if (sync_raw == filt_p1) begin
        cnt_p1 <= '0;
      end else if (cnt_p1 == CNT_LAST) begin
        filt_p1 <= sync_raw;
        cnt_p1  <= '0;
      end else begin
        cnt_p1 <= cnt_inc(cnt_p1);
      end
    end

    // Stage 2: delayed level for edge detection.
    always_ff @(posedge clk_b) begin
      if (!sync_rst_n) begin
        filt_d_p2 <= RESET_VAL[ch];
      end else begin
        filt_d_p2 <= filt_p1;
      end
    end

    assign level_out[ch]  = filt_p1;
    assign rise_pulse[ch] = filt_p1 & ~filt_d_p2;
    assign fall_pulse[ch] = ~filt_p1 & filt_d_p2;
    assign pending[ch]    = (cnt_p1 != '0);
  end

endmodule

// File: tb/tb_cdc_multi_ch_sync_filter.sv
// Directed bench for cdc_multi_ch_sync_filter. There are three instances:
//   dut_a: RESET_VAL=4'b0101 (reset-hold test)
//   dut_b: defaults (latency, glitch, simultaneous events, reset mid-qualify)
//   dut_c: STAGES=3, FILTER_CYCLES=1 (short filter, glitch pass-through)
// Expected per-cycle outputs are queued when stimulus is applied and popped
// and compared one per clock edge.
module tb_cdc_multi_ch_sync_filter;

  typedef struct packed {
    logic [3:0] l;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rst_c;
  logic [3:0] in_a, in_b, in_c;
  logic [3:0] lvl_a, rise_a, fall_a, pend_a;
  logic [3:0] lvl_b, rise_b, fall_b, pend_b;
  logic [3:0] lvl_c, rise_c, fall_c, pend_c;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cdc_multi_ch_sync_filter #(
    .NUM_CH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VAL(4'b0101)
  ) dut_a (
    .clk_b(clk), .sync_rst_n(rst_a), .async_in(in_a),
    .level_out(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .pending(pend_a)
  );

  cdc_multi_ch_sync_filter #(
    .NUM_CH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VAL(4'b0000)
  ) dut_b (
    .clk_b(clk), .sync_rst_n(rst_b), .async_in(in_b),
    .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .pending(pend_b)
  );

  cdc_multi_ch_sync_filter #(
    .NUM_CH(4), .STAGES(3), .FILTER_CYCLES(1), .RESET_VAL(4'b0000)
  ) dut_c (
    .clk_b(clk), .sync_rst_n(rst_c), .async_in(in_c),
    .level_out(lvl_c), .rise_pulse(rise_c), .fall_pulse(fall_c), .pending(pend_c)
  );

  task automatic push(input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] p);
    exp_t e;
    e.l = l;
    e.r = r;
    e.f = f;
    e.p = p;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // One queued expectation per clock edge, sampled 1 time unit after it.
  task automatic drain(input int d, input string tag);
    exp_t       e;
    logic [3:0] ol, orr, ofl, op;
    int         k;
    k = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      case (d)
        0:       begin ol = lvl_a; orr = rise_a; ofl = fall_a; op = pend_a; end
        1:       begin ol = lvl_b; orr = rise_b; ofl = fall_b; op = pend_b; end
        default: begin ol = lvl_c; orr = rise_c; ofl = fall_c; op = pend_c; end
      endcase
      chk($sformatf("%s[%0d].level", tag, k), ol, e.l);
      chk($sformatf("%s[%0d].rise", tag, k), orr, e.r);
      chk($sformatf("%s[%0d].fall", tag, k), ofl, e.f);
      chk($sformatf("%s[%0d].pending", tag, k), op, e.p);
      k++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    in_a  = 4'b0101; in_b = 4'b0000; in_c = 4'b0000;

    // Two reset edges, then ten running cycles with input equal to RESET_VAL.
    @(posedge clk);
    #1;
    push(4'b0101, 4'b0000, 4'b0000, 4'b0000);
    drain(0, "t1_rst");
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (10) push(4'b0101, 4'b0000, 4'b0000, 4'b0000);
    drain(0, "t1_run");

    // Channel 0 rises: pending after E+2 and E+3, level and rise after E+4.
    in_b[0] = 1'b1;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    drain(1, "t2");

    // Channel 1 high for exactly two samples: pending twice, no level change.
    in_b[1] = 1'b1;
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    drain(1, "t3a");
    in_b[1] = 1'b0;
    push(4'b0001, 4'b0000, 4'b0000, 4'b0010);
    push(4'b0001, 4'b0000, 4'b0000, 4'b0010);
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    drain(1, "t3b");

    // Bring channel 3 high first.
    in_b[3] = 1'b1;
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0001, 4'b0000, 4'b0000, 4'b1000);
    push(4'b0001, 4'b0000, 4'b0000, 4'b1000);
    push(4'b1001, 4'b1000, 4'b0000, 4'b0000);
    push(4'b1001, 4'b0000, 4'b0000, 4'b0000);
    drain(1, "t4pre");

    // Channel 2 rises and channel 3 falls at the same edge.
    in_b[2] = 1'b1;
    in_b[3] = 1'b0;
    push(4'b1001, 4'b0000, 4'b0000, 4'b0000);
    push(4'b1001, 4'b0000, 4'b0000, 4'b0000);
    push(4'b1001, 4'b0000, 4'b0000, 4'b1100);
    push(4'b1001, 4'b0000, 4'b0000, 4'b1100);
    push(4'b0101, 4'b0100, 4'b1000, 4'b0000);
    push(4'b0101, 4'b0000, 4'b0000, 4'b0000);
    drain(1, "t4");

    // Reset in the middle of a qualification on channel 0.
    in_b  = 4'b0000;
    rst_b = 1'b0;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drain(1, "t5_rst0");
    rst_b   = 1'b1;
    in_b[0] = 1'b1;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0001);
    drain(1, "t5_qual");
    rst_b = 1'b0;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drain(1, "t5_rst1");
    rst_b = 1'b1;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0001);
    push(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    drain(1, "t5_rel");

    // STAGES=3, FILTER_CYCLES=1: level follows four edges after first sample.
    in_c[0] = 1'b1;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    drain(2, "t6_rise");
    in_c[0] = 1'b0;
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0001, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drain(2, "t6_fall");

    // One-sample glitch passes straight through: rise then fall next cycle.
    in_c[0] = 1'b1;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drain(2, "t6_g0");
    in_c[0] = 1'b0;
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0001, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drain(2, "t6_g1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_multi_ch_sync_filter.md
Name: cdc_multi_ch_sync_filter

Overview:
- Parametrised multi-channel synchronizer for asynchronous single-bit inputs entering the clk_b domain. It generalises the fixed two-flop synchronizer.
- Each channel gets:
  - a configurable-depth flop chain,
  - a stability (glitch) filter,
  - registered rise and fall event pulses.
- Placed at the boundary of the receiving domain. It feeds control FSMs that need clean levels and single-cycle edge events.

Parameters:
- NUM_CH, 4, number of independent single-bit channels (>=1).
- STAGES, 2, synchronizer flop depth per channel (>=2). Elaboration error if <2.
- FILTER_CYCLES, 3, consecutive cycles the synchronized value must differ from the filtered level before the level updates (>=1). Elaboration error if <1.
- RESET_VAL, {NUM_CH{1'b0}}, per-channel reset level for chain flops and filtered level.

Ports:
- clk_b  input  1  destination-domain clock; all flops on posedge.
- sync_rst_n  input  1  synchronous reset, active-low, sampled on posedge clk_b.
- async_in  input  NUM_CH  asynchronous inputs, one bit per channel.
- level_out  output  NUM_CH  filtered synchronized level.
- rise_pulse  output  NUM_CH  one-cycle pulse when level_out goes 0->1.
- fall_pulse  output  NUM_CH  one-cycle pulse when level_out goes 1->0.
- pending  output  NUM_CH  high while a channel's filter counter is non-zero, i.e. a change is qualifying.

Behaviour:
- Channels are fully independent. All logic below is per channel i.
- Sync chain:
  - s[0] <= async_in[i]; s[k] <= s[k-1].
  - sync_raw = s[STAGES-1].
  - No logic between chain flops.
  - async_in feeds only s[0].
- Filter:
  - Counter width is $clog2(FILTER_CYCLES+1).
  - If sync_raw == filt: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: filt <= sync_raw, cnt <= 0.
  - Else: cnt <= cnt+1.
  - level_out = filt.
- Edge detect:
  - filt_d <= filt.
  - rise_pulse = filt & ~filt_d.
  - fall_pulse = ~filt & filt_d.
  - Each pulse is high exactly one cycle: the first cycle of the new level_out value.
- pending = (cnt != 0).
- Latency: a change on async_in that is stable and meets setup at posedge E appears on level_out after posedge E+STAGES+FILTER_CYCLES-1 (STAGES+FILTER_CYCLES edges including E).
  - Defaults: level_out changes 5 edges after the input is first sampled.
- Glitch rejection:
  - A sync_raw excursion shorter than FILTER_CYCLES cycles never changes level_out and never pulses.
  - cnt returns to 0 the cycle after sync_raw matches filt again.
- Alternating input: sync_raw toggling every cycle never qualifies when FILTER_CYCLES>=2.
- Reset (sync_rst_n==0 at a posedge):
  - s[*], filt and filt_d load RESET_VAL[i]; cnt loads 0.
  - Reset overrides any in-progress qualification.
  - Outputs after the reset edge: level_out=RESET_VAL, rise/fall_pulse=0, pending=0.
  - Before the first reset edge, outputs are undefined.
- After reset release:
  - If async_in == RESET_VAL: no pulse and no pending at any cycle.
  - If async_in != RESET_VAL: the normal full latency applies from the first post-reset edge.
- Simultaneous events: any mix of channels may pulse in the same cycle. rise_pulse[i] and fall_pulse[i] are never both high.
- No saturation or wrap: cnt is bounded by FILTER_CYCLES-1.

Test Plan:
(Parameters STAGES=2, FILTER_CYCLES=3, NUM_CH=4 unless stated.)
1. RESET_VAL=4'b0101, async_in=4'b0101, hold sync_rst_n=0 for 2 edges then release, run 10 cycles -> level_out=4'b0101 throughout, rise/fall_pulse=0, pending=0.
2. RESET_VAL=0; async_in[0] 0->1 stable before edge E -> level_out[0]=1 after edge E+4; rise_pulse[0]=1 for exactly that one cycle; pending[0]=1 after edges E+2 and E+3.
3. async_in[1] high for exactly 2 cycles then low -> level_out[1] stays 0, no pulses; pending[1] high for 2 cycles, then 0.
4. async_in[2] 0->1 and async_in[3] 1->0 (level_out[3]=1 beforehand) at the same edge -> rise_pulse[2] and fall_pulse[3] asserted in the same cycle; other pulse bits 0.
5. async_in[0] 0->1, assert sync_rst_n=0 for one edge when pending[0]=1 with cnt=2, keep input high -> after the reset edge level_out[0]=0 and pending=0 with no pulse; level_out[0]=1 exactly 5 edges after release, with one rise_pulse[0].
6. STAGES=3, FILTER_CYCLES=1, async_in[0] 0->1 -> level_out[0] changes 4 edges after first sample; a 1-cycle sync_raw glitch is passed through, producing one rise_pulse and one fall_pulse one cycle apart.
